// File: rtl/ext_mem_loader.sv
// Host-side loader for the RISC-V CPU top: streams operand words into data memory
// through the external write port, releases CPU reset, then watches the store bus.
module ext_mem_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0200_0000,
    parameter int          NUM_WORDS      = 3,
    parameter int          RESULT_OFFSET  = 4,
    parameter int          DONE_OFFSET    = 8,
    parameter int          RESET_HOLD     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_WriteData,
    output logic [31:0] Ext_DataAdr,
    output logic        cpu_reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    localparam logic [31:0] RESULT_ADDR = BASE_ADDR + 32'(RESULT_OFFSET);
    localparam logic [31:0] DONE_ADDR   = BASE_ADDR + 32'(DONE_OFFSET);
    localparam logic [7:0]  LAST_IDX    = 8'(NUM_WORDS - 1);
    localparam logic [31:0] HOLD_LAST   = 32'(RESET_HOLD - 1);
    localparam logic [31:0] RUN_LAST    = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t      state;
    logic [7:0]  word_idx;
    // Shared between HOLD (reset-hold length) and RUN (timeout watchdog).
    logic [31:0] cycle_cnt;

    logic res_hit;
    logic done_hit;

    assign in_ready = (state == S_LOAD);
    assign res_hit  = MemWrite && (DataAdr == RESULT_ADDR);
    assign done_hit = MemWrite && (DataAdr == DONE_ADDR) && (WriteData == 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            word_idx      <= '0;
            cycle_cnt     <= '0;
            Ext_MemWrite  <= 1'b0;
            Ext_WriteData <= '0;
            Ext_DataAdr   <= '0;
            cpu_reset     <= 1'b1;
            result        <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            // The external write strobe is a single-cycle pulse; idle value is all zero.
            Ext_MemWrite  <= 1'b0;
            Ext_WriteData <= '0;
            Ext_DataAdr   <= '0;

            case (state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (start) begin
                        state        <= S_LOAD;
                        busy         <= 1'b1;
                        cpu_reset    <= 1'b1;
                        word_idx     <= '0;
                        result       <= '0;
                        result_valid <= 1'b0;
                        done         <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (in_valid) begin
                        Ext_MemWrite  <= 1'b1;
                        Ext_WriteData <= in_data;
                        Ext_DataAdr   <= BASE_ADDR + {22'd0, word_idx, 2'b00};
                        word_idx      <= word_idx + 8'd1;
                        if (word_idx == LAST_IDX) begin
                            state     <= S_HOLD;
                            cycle_cnt <= '0;
                        end
                    end
                end

                S_HOLD: begin
                    if (cycle_cnt == HOLD_LAST) begin
                        state     <= S_RUN;
                        cpu_reset <= 1'b0;
                        cycle_cnt <= '0;
                    end else begin
                        cycle_cnt <= cycle_cnt + 32'd1;
                    end
                end

                S_RUN: begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                    if (res_hit)
                        result <= WriteData;
                    // Done wins over a timeout landing on the same cycle.
                    if (done_hit) begin
                        state        <= S_DONE;
                        done         <= 1'b1;
                        result_valid <= 1'b1;
                        cpu_reset    <= 1'b1;
                        busy         <= 1'b0;
                    end else if (cycle_cnt == RUN_LAST) begin
                        state     <= S_TIMEOUT;
                        timeout   <= 1'b1;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    cpu_reset <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed + randomized bench for ext_mem_loader; expectations come from a
// word-list / store-list model of the load and monitor rules.
module tb_ext_mem_loader;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [31:0] RES  = BASE + 32'd4;
    localparam logic [31:0] DNE  = BASE + 32'd8;
    localparam int          N    = 3;
    localparam int          TMO  = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        Ext_MemWrite;
    logic [31:0] Ext_WriteData;
    logic [31:0] Ext_DataAdr;
    logic        cpu_reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;
    logic        done;
    logic        timeout;

    int          total = 0;
    int          bad   = 0;
    int          pulses = 0;
    logic [31:0] words[N];
    int          stall[N];
    logic [31:0] exp_result;

    ext_mem_loader #(
        .BASE_ADDR(BASE), .NUM_WORDS(N), .RESULT_OFFSET(4), .DONE_OFFSET(8),
        .RESET_HOLD(2), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .Ext_MemWrite(Ext_MemWrite), .Ext_WriteData(Ext_WriteData),
        .Ext_DataAdr(Ext_DataAdr), .cpu_reset(cpu_reset), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData), .result(result),
        .result_valid(result_valid), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (Ext_MemWrite) pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a start from IDLE/DONE/TIMEOUT; flags must be cleared.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_result = '0;
        chk("start_in_ready", in_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_timeout", timeout, 0);
        chk("start_rvalid", result_valid, 0);
        chk("start_result", result, 0);
        chk("start_cpu_reset", cpu_reset, 1);
    endtask

    // Word k must appear on the Ext port the cycle after its acceptance at BASE+4k.
    task automatic do_load(input int upto);
        for (int k = 0; k < upto; k++) begin
            for (int s = 0; s < stall[k]; s++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                step();
                chk("stall_no_write", Ext_MemWrite, 0);
                chk("stall_adr_zero", Ext_DataAdr, 0);
            end
            in_valid = 1'b1;
            in_data  = words[k];
            chk("load_in_ready", in_ready, 1);
            step();
            chk("ext_we", Ext_MemWrite, 1);
            chk("ext_adr", Ext_DataAdr, BASE + 32'(4 * k));
            chk("ext_data", Ext_WriteData, words[k]);
        end
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    // Start, load all words, walk the reset-hold window into RUN.
    task automatic run_full();
        int p0;
        do_start();
        p0 = pulses;
        do_load(N);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_cpu_reset0", cpu_reset, 1);
        chk("hold_busy", busy, 1);
        step();
        chk("hold_we_drop", Ext_MemWrite, 0);
        chk("hold_cpu_reset1", cpu_reset, 1);
        step();
        chk("run_cpu_reset", cpu_reset, 0);
        chk("run_busy", busy, 1);
        chk("write_pulses", 32'(pulses - p0), N);
    endtask

    // One CPU store cycle; the model applies the monitor rules to it.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        if (a == RES) exp_result = d;
        step();
        MemWrite  = 1'b0;
        DataAdr   = $urandom;
        WriteData = $urandom;
    endtask

    task automatic finish_done(input string tag);
        store(DNE, 32'd1);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_rvalid"}, result_valid, 1);
        chk({tag, "_result"}, result, exp_result);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic random_stores(input int n);
        logic [31:0] a, d;
        int          sel;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 3);
            d   = $urandom;
            case (sel)
                0:       a = RES;
                1:       a = DNE;
                2:       a = BASE + 32'($urandom_range(0, 15) * 4);
                default: a = $urandom;
            endcase
            if (a == DNE && d == 32'd1) d = 32'd2;
            if (sel == 3 && $urandom_range(0, 1) == 0) step();
            else store(a, d);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        exp_result = '0;
        step(); step();
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_we", Ext_MemWrite, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {28'd0, result_valid, done, timeout, Ext_DataAdr != 0}, 0);
        reset = 1'b0;
        step();

        // Sum-of-N: back-to-back words 10,0,0; CPU stores 55 then done.
        words = '{32'd10, 32'd0, 32'd0};
        stall = '{0, 0, 0};
        run_full();
        chk("run_ext_idle", Ext_MemWrite, 0);
        store(RES, 32'd55);
        finish_done("sum");

        // Stalling host (valid 1,0,0,1,0,1) plus monitor filtering.
        words = '{$urandom, $urandom, $urandom};
        stall = '{0, 2, 1};
        run_full();
        store(RES, 32'd7);
        store(DNE, 32'd2);
        chk("filter_not_done", done, 0);
        chk("filter_busy", busy, 1);
        store(RES, 32'd9);
        finish_done("filter");

        // Timeout with a start pulse mid-RUN that must be ignored.
        words = '{$urandom, $urandom, $urandom};
        stall = '{1, 0, 0};
        run_full();
        for (int i = 0; i < TMO; i++) begin
            start = (i == 10);
            if (i % 7 == 3) begin
                MemWrite = 1'b1; DataAdr = RES; WriteData = $urandom;
                exp_result = WriteData;
            end else if (i == 20) begin
                MemWrite = 1'b1; DataAdr = DNE; WriteData = 32'd3;
            end
            step();
            start = 1'b0; MemWrite = 1'b0;
            if (i == 10) chk("start_ignored_busy", busy, 1);
            if (i == 10) chk("start_ignored_cpu", cpu_reset, 0);
            if (i == TMO - 2) chk("tmo_not_yet", timeout, 0);
        end
        chk("tmo_flag", timeout, 1);
        chk("tmo_done", done, 0);
        chk("tmo_rvalid", result_valid, 0);
        chk("tmo_cpu_reset", cpu_reset, 1);
        chk("tmo_result", result, exp_result);
        chk("tmo_busy", busy, 0);

        // Reload after timeout, then reset after the second word.
        words = '{$urandom, $urandom, $urandom};
        stall = '{0, 1, 0};
        do_start();
        do_load(2);
        reset = 1'b1;
        #1;
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_we", Ext_MemWrite, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        step();
        reset = 1'b0;
        step();
        chk("midrst_idle_ready", in_ready, 0);
        words = '{$urandom, $urandom, $urandom};
        stall = '{0, 0, 2};
        run_full();
        random_stores(5);
        finish_done("after_rst");

        // Randomized runs: random words, host stalls and store traffic.
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < N; k++) begin
                words[k] = $urandom;
                stall[k] = $urandom_range(0, 2);
            end
            run_full();
            random_stores($urandom_range(1, 10));
            finish_done("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
